// File: rtl/iob_soc_sut_iob_arbiter.sv
// rtl/iob_soc_sut_iob_arbiter.sv - round-robin arbiter sharing one IOb-native slave between N_MASTERS requesters
//
// Purpose:
//   Grants the shared slave port to one master at a time, round-robin, with one
//   transaction in flight. A write releases the grant when the slave accepts it.
//   A read holds the grant until the slave returns rvalid.
//
// Optional feature (macro IOB_SOC_SUT_ARB_TIMEOUT_EN):
//   A read-response watchdog. After TIMEOUT_CYCLES cycles in WAIT_R with no
//   s_rvalid_i, the granted master gets a one-cycle rvalid with all-ones data.
//   timeout_o is then set and stays set until reset. When the macro is
//   undefined, WAIT_R waits indefinitely and timeout_o is tied to 0.
//
// Ports:
//   clk_i, arst_n_i          clock; asynchronous active-low reset
//   m_avalid_i  [N]          per-master request valid
//   m_addr_i    [N*ADDR_W]   per-master address (master k at slice k)
//   m_wdata_i   [N*DATA_W]   per-master write data
//   m_wstrb_i   [N*DATA_W/8] per-master write strobe (all zero = read)
//   m_rdata_o   [N*DATA_W]   per-master read data (0 outside the owner's response)
//   m_rvalid_o  [N]          per-master read-data valid
//   m_ready_o   [N]          per-master request accepted
//   s_avalid_o, s_addr_o, s_wdata_o, s_wstrb_o   shared slave request
//   s_rdata_i, s_rvalid_i, s_ready_i             shared slave response
//   grant_o     [N]          one-hot current owner, zero when idle
//   timeout_o                sticky watchdog flag
module iob_soc_sut_iob_arbiter #(
  parameter int N_MASTERS      = 2,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk_i,
  input  logic                            arst_n_i,
  input  logic [N_MASTERS-1:0]            m_avalid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata_i,
  input  logic [N_MASTERS*(DATA_W/8)-1:0] m_wstrb_i,
  output logic [N_MASTERS*DATA_W-1:0]     m_rdata_o,
  output logic [N_MASTERS-1:0]            m_rvalid_o,
  output logic [N_MASTERS-1:0]            m_ready_o,
  output logic                            s_avalid_o,
  output logic [ADDR_W-1:0]               s_addr_o,
  output logic [DATA_W-1:0]               s_wdata_o,
  output logic [(DATA_W/8)-1:0]           s_wstrb_o,
  input  logic [DATA_W-1:0]               s_rdata_i,
  input  logic                            s_rvalid_i,
  input  logic                            s_ready_i,
  output logic [N_MASTERS-1:0]            grant_o,
  output logic                            timeout_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("iob_soc_sut_iob_arbiter: N_MASTERS must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_WAIT_R = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [N_MASTERS-1:0] r_grant;
  logic [N_MASTERS-1:0] w_grant_nxt;
  logic [IDX_W-1:0]     r_gidx;
  logic [IDX_W-1:0]     w_gidx_nxt;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     w_ptr_nxt;
  logic [IDX_W-1:0]     w_ptr_inc;
  logic                 w_found;
  logic [IDX_W-1:0]     w_win;
  logic [IDX_W:0]       w_cand;
  logic                 w_g_avalid;
  logic                 w_g_write;
  logic                 w_timeout_hit;

  // Round-robin search: first requester at or after r_ptr, wrapping modulo N_MASTERS.
  // w_cand has one extra bit so that r_ptr + i cannot overflow before the wrap.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      w_cand = {1'b0, r_ptr} + (IDX_W+1)'(i);
      if (w_cand >= (IDX_W+1)'(N_MASTERS)) begin
        w_cand = w_cand - (IDX_W+1)'(N_MASTERS);
      end
      if (!w_found && m_avalid_i[w_cand[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[IDX_W-1:0];
      end
    end
  end

  assign w_ptr_inc  = (r_gidx == IDX_W'(N_MASTERS - 1)) ? '0 : r_gidx + IDX_W'(1);
  assign w_g_avalid = m_avalid_i[r_gidx];
  assign w_g_write  = |m_wstrb_i[r_gidx*STRB_W +: STRB_W];
  assign grant_o    = r_grant;

`ifdef IOB_SOC_SUT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  // The counter holds the number of completed WAIT_R cycles. The watchdog fires
  // in the TIMEOUT_CYCLES-th cycle of WAIT_R if the slave has not responded.
  assign w_timeout_hit = (r_state == S_WAIT_R) && !s_rvalid_i &&
                         (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_o     = r_timeout;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == S_WAIT_R && w_state_nxt == S_WAIT_R) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
      if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end
`else
  assign w_timeout_hit = 1'b0;
  assign timeout_o     = 1'b0;
`endif

  // Next-state logic and all combinational outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_ptr_nxt   = r_ptr;
    s_avalid_o  = 1'b0;
    s_addr_o    = '0;
    s_wdata_o   = '0;
    s_wstrb_o   = '0;
    m_ready_o   = '0;
    m_rvalid_o  = '0;
    m_rdata_o   = '0;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt        = S_GRANT;
          w_gidx_nxt         = w_win;
          w_grant_nxt        = '0;
          w_grant_nxt[w_win] = 1'b1;
        end
      end

      S_GRANT: begin
        s_avalid_o        = w_g_avalid;
        s_addr_o          = m_addr_i[r_gidx*ADDR_W +: ADDR_W];
        s_wdata_o         = m_wdata_i[r_gidx*DATA_W +: DATA_W];
        s_wstrb_o         = m_wstrb_i[r_gidx*STRB_W +: STRB_W];
        m_ready_o[r_gidx] = s_ready_i;

        if (!w_g_avalid) begin
          // The owner withdrew its request before acceptance. Drop the grant
          // and keep the pointer, so the same master keeps its priority.
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
        end else if (s_ready_i) begin
          if (w_g_write) begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_ptr_nxt   = w_ptr_inc;
          end else if (s_rvalid_i) begin
            // The slave answered in the acceptance cycle, so the read is already complete.
            m_rvalid_o[r_gidx]                = 1'b1;
            m_rdata_o[r_gidx*DATA_W +: DATA_W] = s_rdata_i;
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_ptr_nxt   = w_ptr_inc;
          end else begin
            w_state_nxt = S_WAIT_R;
          end
        end
      end

      S_WAIT_R: begin
        if (s_rvalid_i) begin
          m_rvalid_o[r_gidx]                = 1'b1;
          m_rdata_o[r_gidx*DATA_W +: DATA_W] = s_rdata_i;
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = w_ptr_inc;
        end else if (w_timeout_hit) begin
          m_rvalid_o[r_gidx]                = 1'b1;
          m_rdata_o[r_gidx*DATA_W +: DATA_W] = '1;
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = w_ptr_inc;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_iob_soc_sut_iob_arbiter.sv
// tb/tb_iob_soc_sut_iob_arbiter.sv - scoreboard testbench for iob_soc_sut_iob_arbiter
module tb_iob_soc_sut_iob_arbiter;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            arst_n = 1'b0;
  logic [N-1:0]    m_avalid;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [N*DW-1:0] m_rdata;
  logic [N-1:0]    m_rvalid;
  logic [N-1:0]    m_ready;
  logic            s_avalid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic [DW-1:0]   s_rdata;
  logic            s_rvalid;
  logic            s_ready;
  logic [N-1:0]    grant;
  logic            timeout;

  always #5 clk = ~clk;

  iob_soc_sut_iob_arbiter #(
    .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .m_avalid_i(m_avalid), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
    .m_rdata_o(m_rdata), .m_rvalid_o(m_rvalid), .m_ready_o(m_ready),
    .s_avalid_o(s_avalid), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
    .s_rdata_i(s_rdata), .s_rvalid_i(s_rvalid), .s_ready_i(s_ready),
    .grant_o(grant), .timeout_o(timeout)
  );

  // is_rd=0: expected ready pulse, val = address; is_rd=1: expected rvalid, val = data
  typedef struct {
    bit          is_rd;
    int          m;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;
  int   rdy_cnt[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input bit rd, input int m, input logic [31:0] v);
    exp_t e;
    e.is_rd = rd;
    e.m     = m;
    e.val   = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    m_addr[m*AW +: AW]  = a;
    m_wdata[m*DW +: DW] = d;
    m_wstrb[m*SW +: SW] = s;
    m_avalid[m]         = 1'b1;
  endtask

  // Monitor: every ready or rvalid pulse consumes the oldest expectation.
  always @(negedge clk) begin
    if (arst_n) begin
      if (m_ready != '0) begin
        for (int k = 0; k < N; k++) if (m_ready[k]) rdy_cnt[k]++;
        if (sb.size() == 0 || sb[0].is_rd) begin
          chk("unexpected_ready", 64'(m_ready), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("ready_owner", 64'(m_ready), 64'(1 << mon_e.m));
          chk("ready_addr", 64'(s_addr), 64'(mon_e.val));
        end
      end
      if (m_rvalid != '0) begin
        if (sb.size() == 0 || !sb[0].is_rd) begin
          chk("unexpected_rvalid", 64'(m_rvalid), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("rvalid_owner", 64'(m_rvalid), 64'(1 << mon_e.m));
          chk("rvalid_data", 64'(m_rdata), 64'(mon_e.val) << (mon_e.m * DW));
        end
      end
    end
  end

  initial begin
    m_avalid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_rdata = '0; s_rvalid = 1'b0; s_ready = 1'b1; arst_n = 1'b0;
    rdy_cnt = '{0, 0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_s_avalid", 64'(s_avalid), 64'd0);
    chk("rst_m_ready", 64'(m_ready), 64'd0);
    chk("rst_m_rvalid", 64'(m_rvalid), 64'd0);
    chk("rst_m_rdata", 64'(m_rdata), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    s_ready = 1'b0;
    arst_n = 1'b1;
    tick();

    // T1: master 0 write, slave ready one cycle after the grant
    set_req(0, 16'h0010, 32'hA5A5A5A5, 4'hF);
    push(0, 0, 32'h0010);
    #1 chk("t1_latency_s_avalid", 64'(s_avalid), 64'd0);
    tick();
    chk("t1_s_avalid", 64'(s_avalid), 64'd1);
    chk("t1_grant", 64'(grant), 64'b01);
    chk("t1_s_wdata", 64'(s_wdata), 64'hA5A5A5A5);
    chk("t1_s_wstrb", 64'(s_wstrb), 64'hF);
    s_ready = 1'b1;
    #1 chk("t1_m_ready", 64'(m_ready), 64'b01);
    tick();
    m_avalid = '0; s_ready = 1'b0;
    #1 chk("t1_grant_idle", 64'(grant), 64'd0);

    // T2: master 1 read; requester and slave keep avalid/ready high during WAIT_R
    set_req(1, 16'h0004, 32'h0, 4'h0);
    push(0, 1, 32'h0004);
    tick();
    chk("t2_grant", 64'(grant), 64'b10);
    chk("t2_s_addr", 64'(s_addr), 64'h0004);
    chk("t2_s_wstrb", 64'(s_wstrb), 64'h0);
    s_ready = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      #1 chk("t2_wait_s_avalid", 64'(s_avalid), 64'd0);
      chk("t2_wait_m_ready", 64'(m_ready), 64'd0);
      tick();
    end
    m_avalid = '0; s_ready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h12345678;
    push(1, 1, 32'h12345678);
    #1 chk("t2_m_rvalid", 64'(m_rvalid), 64'b10);
    chk("t2_m_rdata", 64'(m_rdata), {32'h12345678, 32'h0});
    tick();
    s_rvalid = 1'b0;
    #1 chk("t2_grant_idle", 64'(grant), 64'd0);

    // T3: both masters stream writes; expect strict alternation 0,1,0,1...
    rdy_cnt = '{0, 0};
    for (int k = 0; k < 4; k++) begin
      push(0, 0, 32'h0100);
      push(0, 1, 32'h0200);
    end
    set_req(0, 16'h0100, 32'h11110000, 4'hF);
    set_req(1, 16'h0200, 32'h22220000, 4'h3);
    s_ready = 1'b1;
    repeat (16) tick();
    m_avalid = '0; s_ready = 1'b0;
    #1 chk("t3_grant_idle", 64'(grant), 64'd0);
    chk("t3_m0_ready_count", 64'(rdy_cnt[0]), 64'd4);
    chk("t3_m1_ready_count", 64'(rdy_cnt[1]), 64'd4);

    // T4: master 0 read holds the slave while master 1 waits
    set_req(0, 16'h0020, 32'h0, 4'h0);
    set_req(1, 16'h0030, 32'hDEADBEEF, 4'hF);
    push(0, 0, 32'h0020);
    tick();
    chk("t4_grant_m0", 64'(grant), 64'b01);
    s_ready = 1'b1;
    tick();
    m_avalid[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t4_wait_grant", 64'(grant), 64'b01);
      chk("t4_wait_m_ready", 64'(m_ready), 64'd0);
      tick();
    end
    s_rvalid = 1'b1; s_rdata = 32'hCAFEF00D;
    push(1, 0, 32'hCAFEF00D);
    push(0, 1, 32'h0030);
    #1 chk("t4_rvalid_m_ready", 64'(m_ready), 64'd0);
    tick();
    s_rvalid = 1'b0;
    #1 chk("t4_idle_grant", 64'(grant), 64'd0);
    tick();
    chk("t4_grant_m1", 64'(grant), 64'b10);
    tick();
    m_avalid = '0; s_ready = 1'b0;

    // T4b: ready and rvalid in the same GRANT cycle completes the read directly
    set_req(0, 16'h0050, 32'h0, 4'h0);
    push(0, 0, 32'h0050);
    push(1, 0, 32'h0BADF00D);
    tick();
    s_ready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h0BADF00D;
    #1 chk("t4b_m_rvalid", 64'(m_rvalid), 64'b01);
    tick();
    m_avalid = '0; s_ready = 1'b0; s_rvalid = 1'b0;
    #1 chk("t4b_direct_idle", 64'(grant), 64'd0);

    // T5: reset during a master 1 read; late rvalid ignored; pointer back to 0
    set_req(1, 16'h0060, 32'h0, 4'h0);
    push(0, 1, 32'h0060);
    tick();
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0; m_avalid = '0;
    #1 chk("t5_wait_grant", 64'(grant), 64'b10);
    arst_n = 1'b0; s_ready = 1'b1;
    #1 chk("t5_rst_grant", 64'(grant), 64'd0);
    chk("t5_rst_s_avalid", 64'(s_avalid), 64'd0);
    chk("t5_rst_m_ready", 64'(m_ready), 64'd0);
    s_rvalid = 1'b1; s_rdata = 32'h55555555;
    #1 chk("t5_rst_m_rvalid", 64'(m_rvalid), 64'd0);
    chk("t5_rst_m_rdata", 64'(m_rdata), 64'd0);
    tick();
    arst_n = 1'b1;
    #1 chk("t5_late_rvalid", 64'(m_rvalid), 64'd0);
    chk("t5_late_grant", 64'(grant), 64'd0);
    s_rvalid = 1'b0;
    set_req(0, 16'h0070, 32'h00000077, 4'hF);
    set_req(1, 16'h0080, 32'h00000088, 4'hF);
    push(0, 0, 32'h0070);
    push(0, 1, 32'h0080);
    tick();
    chk("t5_first_after_reset", 64'(grant), 64'b01);
    tick();
    tick();
    chk("t5_second_after_reset", 64'(grant), 64'b10);
    tick();
    m_avalid = '0; s_ready = 1'b0;

`ifdef IOB_SOC_SUT_ARB_TIMEOUT_EN
    // T6: slave never answers a read; watchdog fires in the 16th WAIT_R cycle
    set_req(0, 16'h0090, 32'h0, 4'h0);
    push(0, 0, 32'h0090);
    tick();
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0; m_avalid = '0;
    for (int k = 1; k < TO; k++) begin
      #1 chk("t6_no_early_rvalid", 64'(m_rvalid), 64'd0);
      tick();
    end
    push(1, 0, 32'hFFFFFFFF);
    #1 chk("t6_timeout_rvalid", 64'(m_rvalid), 64'b01);
    chk("t6_timeout_data", 64'(m_rdata[31:0]), 64'hFFFFFFFF);
    tick();
    chk("t6_timeout_flag", 64'(timeout), 64'd1);
    chk("t6_grant_idle", 64'(grant), 64'd0);
    repeat (3) tick();
    chk("t6_timeout_sticky", 64'(timeout), 64'd1);
`endif

    repeat (3) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
